slow_fifo_byte_unpacker: RTL
============================

Name: slow_fifo_byte_unpacker

Overview:
Read-side consumer of the combined slow sample FIFO. Each 36-bit FIFO word holds three 12-bit ADC samples; this block pops words and serialises them into a byte stream for the USB read path. Supports a packed 12-bit mode (two words become 9 bytes) and an 8-bit mode (one word becomes 3 bytes, upper 8 bits of each sample). Sits in the FIFO read-clock domain, between the FIFO dout/empty/rd port and the USB read engine.

Parameters:
pBYTECNT_W, 32, width of the emitted-byte counter
pPATTERN_SEED, 12'h000, first sample value in test-pattern mode (optional feature only)

Ports:
clk  in  1  FIFO read clock; the only clock
rst_n  in  1  asynchronous active-low reset
mode_8bit  in  1  1 = 8-bit mode, 0 = packed 12-bit mode; sampled only in IDLE
clear  in  1  synchronous flush: discard buffered data, return to IDLE, zero counter
flush  in  1  level; end of capture: emit the padded partial byte group
fifo_empty  in  1  FIFO empty flag (first-word-fall-through)
fifo_dout  in  36  FIFO head word; valid while !fifo_empty
fifo_rd  out  1  pop strobe; combinational
out_data  out  8  byte to USB
out_valid  out  1  byte valid
out_ready  in  1  USB accepts byte
byte_count  out  pBYTECNT_W  bytes accepted (out_valid && out_ready) since reset/clear
idle  out  1  no buffered data and FSM in IDLE
fifo_underflow_err  out  1  sticky; set if fifo_rd is ever asserted while fifo_empty

Behaviour:
- Reset values: out_valid=0, out_data=0, fifo_rd=0, byte_count=0, idle=1, fifo_underflow_err=0, FSM=IDLE, mode latch=0.
- Word layout: s0=[35:24], s1=[23:12], s2=[11:0]. Bytes go out MSB-first.
- 12-bit mode: words A then B form 72-bit {A,B}; 9 bytes emitted as bits [71:64] down to [7:0].
- 8-bit mode: bytes are s0[11:4], s1[11:4], s2[11:4].
- FSM states: IDLE, LOAD_A, LOAD_B, EMIT, PAD.
- IDLE: latch mode_8bit and go to LOAD_A.
- LOAD_A: on !fifo_empty, pulse fifo_rd and capture word A.
  - 8-bit mode: go to EMIT (3 bytes).
  - 12-bit mode: go to LOAD_B.
- LOAD_B: on !fifo_empty, pop and capture B, then go to EMIT (9 bytes). If flush=1 and fifo_empty, go to PAD instead.
- PAD: A alone gives 36 bits. Emit 5 bytes: A[35:28], A[27:20], A[19:12], A[11:4], {A[3:0],4'b0}.
- EMIT/PAD: out_valid=1. Advance the byte index on out_ready; after the last byte, go to LOAD_A.
  - If the next word is already available, fifo_rd may pop it in the same cycle as the last byte's handshake, so throughput has no bubble.
  - Without a same-cycle pop, one idle cycle is allowed between groups.
- Latency: first out_valid one clk after the cycle in which the completing word is popped.
- Handshake: out_data and out_valid hold stable while out_valid && !out_ready. out_valid never drops without a handshake, except on clear or reset.
- fifo_rd is asserted only when !fifo_empty and the block is in LOAD_A/LOAD_B, or in the overlapped case above. At most one pop per clk.
- byte_count increments by 1 per handshake and wraps modulo 2^pBYTECNT_W.
- Mode is captured only in IDLE; a change mid-group takes effect after the next clear.
- Boundary conditions:
  - clear has priority over every other input. Same-cycle clear and handshake: the byte is not counted.
  - flush in LOAD_A with fifo_empty: stay in LOAD_A, no output.
  - fifo_empty asserted mid-EMIT: no effect.
  - Reset mid-operation: all state lost, buffered bytes dropped.

Optional Feature:
SLOW_UNPACK_TESTPATTERN_EN
- Defined: fifo_dout is ignored; every word the block pops is replaced by three consecutive 12-bit counter values, starting at pPATTERN_SEED and wrapping at 12'hFFF.
  - The counter advances per popped sample and resets on rst_n/clear.
  - Pop timing and fifo_rd behaviour are unchanged.
- Undefined: no counter logic; fifo_dout is used directly.

Decomposition:
- Shared package: FSM state encoding, byte counts per group (3, 9, 5), sample width 12, word width 36.
- Natural sub-module: slow_unpack_byte_mux, a combinational selector of out_data from {A,B}, byte index, mode and pad flag. The FSM, counters and pattern generator stay in the top.

Test Plan:
- 8-bit mode, FIFO holds 36'hABC_123_456, out_ready=1: bytes AB,12,45 emitted; one fifo_rd pulse; byte_count=3.
- 12-bit mode, words 36'h123456789 then 36'hABCDEF012: bytes 12,34,56,78,9A,BC,DE,F0,12; two pops; byte_count=9.
- 12-bit mode, one word 36'hFEDCBA987 then flush=1 with FIFO empty: bytes FE,DC,BA,98,70; state returns to LOAD_A.
- out_ready toggled randomly (50%) over 100 words in 8-bit mode: byte stream matches the model; out_data stable during stalls; byte_count=300.
- clear asserted mid-EMIT after 4 of 9 bytes: out_valid=0 next clk, byte_count=0, idle=1; next group starts from a fresh word A.
- Continuous FIFO data, out_ready=1, 8-bit mode: fifo_rd overlaps the last byte; 3 bytes per 3 clks sustained; fifo_underflow_err stays 0.

Source files
------------

// File: rtl/slow_fifo_byte_unpacker_pkg.sv
// Shared definitions for the slow-FIFO byte unpacker: FSM encoding, word geometry and the
// number of bytes emitted per group in each mode.
package slow_fifo_byte_unpacker_pkg;

  localparam int unsigned SampleW = 12;
  localparam int unsigned WordW   = 36;

  // Bytes per group: one word in 8-bit mode, two packed words, or one padded word.
  localparam logic [3:0] Bytes8   = 4'd3;
  localparam logic [3:0] Bytes12  = 4'd9;
  localparam logic [3:0] BytesPad = 4'd5;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StEmit,
    StPad
  } unpack_state_e;

  // Index of the final byte of the current group.
  function automatic logic [3:0] group_last(input logic mode_8bit, input logic pad);
    if (mode_8bit) begin
      return Bytes8 - 4'd1;
    end else if (pad) begin
      return BytesPad - 4'd1;
    end
    return Bytes12 - 4'd1;
  endfunction

endpackage

// File: rtl/slow_unpack_byte_mux.sv
// Combinational byte selector: picks the current output byte from the buffered words A/B.
// 8-bit mode takes the upper 8 bits of each sample of A; packed mode walks {A,B} MSB-first;
// the padded group replaces the fifth byte with A's low nibble followed by zeros.
module slow_unpack_byte_mux
  import slow_fifo_byte_unpacker_pkg::*;
(
  input  logic [WordW-1:0] word_a,
  input  logic [WordW-1:0] word_b,
  input  logic [3:0]       byte_idx,
  input  logic             mode_8bit,
  input  logic             pad,
  output logic [7:0]       byte_out
);

  logic [2*WordW-1:0] pair;
  assign pair = {word_a, word_b};

  // Select the byte addressed by byte_idx for the active group type.
  always_comb begin
    byte_out = '0;
    if (mode_8bit) begin
      case (byte_idx)
        4'd0:    byte_out = word_a[35:28];
        4'd1:    byte_out = word_a[23:16];
        4'd2:    byte_out = word_a[11:4];
        default: byte_out = '0;
      endcase
    end else if (pad && (byte_idx == 4'd4)) begin
      byte_out = {word_a[3:0], 4'b0000};
    end else begin
      case (byte_idx)
        4'd0:    byte_out = pair[71:64];
        4'd1:    byte_out = pair[63:56];
        4'd2:    byte_out = pair[55:48];
        4'd3:    byte_out = pair[47:40];
        4'd4:    byte_out = pair[39:32];
        4'd5:    byte_out = pair[31:24];
        4'd6:    byte_out = pair[23:16];
        4'd7:    byte_out = pair[15:8];
        4'd8:    byte_out = pair[7:0];
        default: byte_out = '0;
      endcase
    end
  end

endmodule

// File: rtl/slow_fifo_byte_unpacker.sv
// Read-side consumer of the slow sample FIFO: pops 36-bit words (three 12-bit samples) and
// serialises them into a valid/ready byte stream, either packed 12-bit (2 words -> 9 bytes)
// or 8-bit (1 word -> 3 bytes). A flush with a lone word A emits a padded 5-byte group.
// Optional build macro SLOW_UNPACK_TESTPATTERN_EN replaces popped data with a sample counter.
module slow_fifo_byte_unpacker
  import slow_fifo_byte_unpacker_pkg::*;
#(
  parameter int unsigned        pBYTECNT_W    = 32,
  parameter logic [SampleW-1:0] pPATTERN_SEED = 12'h000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_8bit,
  input  logic                  clear,
  input  logic                  flush,
  input  logic                  fifo_empty,
  input  logic [WordW-1:0]      fifo_dout,
  output logic                  fifo_rd,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [pBYTECNT_W-1:0] byte_count,
  output logic                  idle,
  output logic                  fifo_underflow_err
);

  unpack_state_e         state_q, state_d;
  logic                  mode_q, mode_d;
  logic [WordW-1:0]      word_a_q, word_a_d;
  logic [WordW-1:0]      word_b_q, word_b_d;
  logic [3:0]            idx_q, idx_d;
  logic [pBYTECNT_W-1:0] count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic [WordW-1:0]      word_in;
  logic                  handshake;
  logic                  is_pad;
  logic                  last_byte;
  logic [7:0]            mux_byte;

`ifdef SLOW_UNPACK_TESTPATTERN_EN
  logic [SampleW-1:0] pat_q, pat_d;
  logic [WordW-1:0]   unused_dout;

  assign unused_dout = fifo_dout;
  assign word_in     = {pat_q, pat_q + 12'd1, pat_q + 12'd2};

  // Pattern counter steps by one sample per sample popped, i.e. three per word.
  always_comb begin
    pat_d = pat_q;
    if (clear) begin
      pat_d = pPATTERN_SEED;
    end else if (fifo_rd) begin
      pat_d = pat_q + 12'd3;
    end
  end

  // Pattern counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= pPATTERN_SEED;
    end else begin
      pat_q <= pat_d;
    end
  end
`else
  logic [SampleW-1:0] unused_seed;

  assign unused_seed = pPATTERN_SEED;
  assign word_in     = fifo_dout;
`endif

  assign out_valid = (state_q == StEmit) || (state_q == StPad);
  assign handshake = out_valid && out_ready;
  assign is_pad    = (state_q == StPad);
  assign last_byte = (idx_q == group_last(mode_q, is_pad));

  // Next-state, pop strobe and buffer capture; clear overrides everything.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    word_a_d = word_a_q;
    word_b_d = word_b_q;
    idx_d    = idx_q;
    fifo_rd  = 1'b0;
    if (clear) begin
      state_d  = StIdle;
      word_a_d = '0;
      word_b_d = '0;
      idx_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          mode_d  = mode_8bit;
          state_d = StLoadA;
        end
        StLoadA: begin
          if (!fifo_empty) begin
            fifo_rd  = 1'b1;
            word_a_d = word_in;
            idx_d    = '0;
            state_d  = mode_q ? StEmit : StLoadB;
          end
        end
        StLoadB: begin
          if (!fifo_empty) begin
            fifo_rd  = 1'b1;
            word_b_d = word_in;
            idx_d    = '0;
            state_d  = StEmit;
          end else if (flush) begin
            idx_d   = '0;
            state_d = StPad;
          end
        end
        StEmit, StPad: begin
          if (handshake) begin
            if (last_byte) begin
              idx_d = '0;
              // Pop the next word A alongside the final handshake to avoid a bubble.
              if (!fifo_empty) begin
                fifo_rd  = 1'b1;
                word_a_d = word_in;
                state_d  = mode_q ? StEmit : StLoadB;
              end else begin
                state_d = StLoadA;
              end
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Accepted-byte counter and sticky underflow flag.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (handshake) begin
      count_d = count_q + pBYTECNT_W'(1);
    end
    underflow_d = underflow_q | (fifo_rd & fifo_empty);
  end

  // State, buffered words and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      word_a_q    <= '0;
      word_b_q    <= '0;
      idx_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      word_a_q    <= word_a_d;
      word_b_q    <= word_b_d;
      idx_q       <= idx_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  slow_unpack_byte_mux u_byte_mux (
    .word_a    (word_a_q),
    .word_b    (word_b_q),
    .byte_idx  (idx_q),
    .mode_8bit (mode_q),
    .pad       (is_pad),
    .byte_out  (mux_byte)
  );

  assign out_data           = out_valid ? mux_byte : 8'h00;
  assign byte_count         = count_q;
  assign idle               = (state_q == StIdle);
  assign fifo_underflow_err = underflow_q;

endmodule
